sw_array_ctrl: RTL and testbench
================================

// Module: sw_array_ctrl
// PURPOSE
//  Sequencer for a linear chain of NUM_PE Smith-Waterman PEs with affine gap scoring.
//  - Loads one short-read base per PE, then streams the reference through PE 0.
//  - Watches the last PE's V output and reports the best local score and its reference column.
//  - Sits between the read/reference stream sources and the systolic array.
//  - PE0 V/F inputs are tied to 0 outside this block.
// PARAMETERS
//  NUM_PE    6   PEs in chain = short-read length loaded per job
//  WIDTH     10  score width, two's complement, matches PE V/F width
//  REF_LEN_W 16  width of ref_len and of max_pos
// PORTS
//  clk        in   1            single clock, all state updates on rising edge
//  rst        in   1            synchronous, active-high
//  start      in   1            job request, sampled only in IDLE
//  ref_len    in   REF_LEN_W    reference bases in job, sampled with start
//  rd_base    in   2            short-read base stream (A=00,C=01,G=10,T=11)
//  rd_valid   in   1            rd_base valid
//  rd_ready   out  1            read base accepted when rd_valid&rd_ready
//  ref_base   in   2            reference base stream
//  ref_valid  in   1            ref_base valid
//  ref_ready  out  1            ref base accepted when ref_valid&ref_ready
//  S_out      out  2            base broadcast to all PE S_in
//  store_S    out  NUM_PE       one-hot PE select for S load; bit k drives PE k
//  T_out      out  2            to PE0 T_in
//  init_out   out  1            to PE0 init_in: T_out carries a real column
//  V_last     in   WIDTH        V_out of PE NUM_PE-1
//  init_last  in   1            init_out of PE NUM_PE-1, qualifies V_last
//  busy       out  1            high in every state except IDLE
//  done       out  1            1-cycle pulse, max_score/max_pos valid
//  max_score  out  WIDTH        best V_last of job, signed
//  max_pos    out  REF_LEN_W    0-based ref column of max_score
// BEHAVIOUR
//  Reset: state=IDLE; store_S=0, init_out=0, T_out=0, S_out=0, rd_ready=0, ref_ready=0.
//   Also busy=0, done=0, max_score=0, max_pos=0, and all counters cleared.
//   Reset mid-job abandons the job: no done pulse, partial results discarded.
//  FSM: IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches ref_len, clears max_score/max_pos/counters -> LOAD. start in other states ignored.
//  LOAD: rd_ready=1. Each accepted base:
//   - registered S_out=rd_base, store_S=one-hot(load_idx) next cycle;
//   - load_idx++.
//   After NUM_PE accepts -> STREAM, or DONE if latched ref_len==0.
//   store_S is 0 on any cycle without an accept.
//  STREAM: ref_ready=1. Each accept gives, next cycle, T_out=ref_base and init_out=1, and ref_cnt++.
//   No accept (ref_valid=0) gives init_out=0, a bubble; T_out holds.
//   After ref_len accepts -> DRAIN; ref_ready drops the same cycle the count is reached.
//  Max tracking runs in STREAM and DRAIN.
//   - col_cnt increments on each init_last=1.
//   - If V_last > max_score (signed, strict), max_score<=V_last and max_pos<=col_cnt.
//   - Ties keep the earliest column; negative V_last never beats initial 0.
//  DRAIN: ref_ready=0, init_out=0; wait until col_cnt==ref_len -> DONE.
//   init_last pulses beyond ref_len are ignored.
//  DONE: done=1 for exactly one cycle, busy=1 -> IDLE. max_score/max_pos hold until next start.
//  Latency: first T_out one cycle after first ref accept. No timeout; a stalled array stalls DRAIN.
//  A start in the DONE cycle is ignored; the earliest new job is the cycle after done.
// STRUCTURE
//  Package sw_pkg: base encodings (BASE_A..BASE_T), state enum sw_ctrl_state_t, WIDTH default.
//  One sub-module: sw_max_tracker (signed compare/update of score and position, clear input).
//  The rest (FSM, load/ref/col counters, output registers) is flat in sw_array_ctrl.
// TESTING (NUM_PE=6; bench models the array as a NUM_PE-cycle delay of init_out
//          and drives V_last from a table)
//  1 rst during STREAM: all outputs 0, busy=0, no done; a following start runs cleanly.
//  2 Load "ACACTA" with rd_valid toggling every cycle:
//    store_S = 000001,000010,...,100000 with S_out = 00,01,00,01,11,00; then rd_ready=0.
//  3 ref_len=8, ref "ACAGACTA", ref_valid held 1 -> 8 consecutive init_out=1 cycles.
//    V_last table {0,2,1,4,3,4,9,7}: done pulses once, max_score=9, max_pos=6.
//  4 Same job with ref_valid low on 2nd and 5th cycles: init_out has 2 bubbles; result still 9/6.
//  5 ref_len=0: LOAD completes -> done next cycle, max_score=0, max_pos=0, no init_out.
//  6 V_last all negative (-4): max_score=0, max_pos=0.
//    Start asserted during STREAM is ignored (one done only).

Source files
------------

// File: rtl/sw_pkg.sv
// ----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the Smith-Waterman array controller:
//   - 2-bit nucleotide encodings
//   - controller state enumeration
//   - default score width (matches the PE V/F datapath)
// ----------------------------------------------------------------------------
package sw_pkg;

  localparam int SW_WIDTH = 10;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } sw_ctrl_state_t;

endpackage

// File: rtl/sw_max_tracker.sv
// ----------------------------------------------------------------------------
// sw_max_tracker
// Keeps the best signed score seen in a job and the column where it occurred.
// The running maximum starts at 0, so negative scores never win, and a strict
// compare keeps the earliest column on ties.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_clr           clear score/position for a new job
//   i_en            i_v/i_pos carry a qualified column result this cycle
//   i_v             candidate score (signed)
//   i_pos           column index of the candidate
//   o_max_score     best score so far (signed)
//   o_max_pos       column of o_max_score
// ----------------------------------------------------------------------------
module sw_max_tracker #(
  parameter int WIDTH = 10,
  parameter int POS_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_v,
  input  logic        [POS_W-1:0] i_pos,
  output logic signed [WIDTH-1:0] o_max_score,
  output logic        [POS_W-1:0] o_max_pos
);

  logic signed [WIDTH-1:0] r_max_score;
  logic        [POS_W-1:0] r_max_pos;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_max_score <= '0;
      r_max_pos   <= '0;
    end else if (i_en && (i_v > r_max_score)) begin
      r_max_score <= i_v;
      r_max_pos   <= i_pos;
    end
  end

  assign o_max_score = r_max_score;
  assign o_max_pos   = r_max_pos;

endmodule

// File: rtl/sw_array_ctrl.sv
// ----------------------------------------------------------------------------
// sw_array_ctrl
// Sequencer for a linear chain of NUM_PE Smith-Waterman PEs (affine gaps).
// Loads one short-read base per PE, streams the reference into PE 0, and
// tracks the best score leaving the last PE together with its column.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, ref_len        job request (sampled in IDLE) and reference length
//   rd_base/valid/ready   short-read base stream
//   ref_base/valid/ready  reference base stream
//   S_out, store_S        read base broadcast + one-hot PE load strobe
//   T_out, init_out       reference base into PE 0 + column-valid flag
//   V_last, init_last     score and column-valid from the last PE
//   busy, done            job in progress / one-cycle completion pulse
//   max_score, max_pos    best score of the job and its 0-based column
// ----------------------------------------------------------------------------
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int NUM_PE    = 6,
  parameter int WIDTH     = SW_WIDTH,
  parameter int REF_LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [REF_LEN_W-1:0]    ref_len,
  input  logic [1:0]              rd_base,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [1:0]              ref_base,
  input  logic                    ref_valid,
  output logic                    ref_ready,
  output logic [1:0]              S_out,
  output logic [NUM_PE-1:0]       store_S,
  output logic [1:0]              T_out,
  output logic                    init_out,
  input  logic signed [WIDTH-1:0] V_last,
  input  logic                    init_last,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] max_score,
  output logic [REF_LEN_W-1:0]    max_pos
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  sw_ctrl_state_t        r_state;
  logic [REF_LEN_W-1:0]  r_ref_len;
  logic [REF_LEN_W-1:0]  r_ref_cnt;
  logic [REF_LEN_W-1:0]  r_col_cnt;
  logic [IDX_W-1:0]      r_load_idx;
  logic [1:0]            r_s_out;
  logic [1:0]            r_t_out;
  logic [NUM_PE-1:0]     r_store_s;
  logic                  r_init_out;

  logic w_clr;
  logic w_track;

  assign w_clr   = (r_state == ST_IDLE) && start;
  // Only the first ref_len columns out of the array belong to this job.
  assign w_track = ((r_state == ST_STREAM) || (r_state == ST_DRAIN)) &&
                   init_last && (r_col_cnt < r_ref_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ref_len  <= '0;
      r_ref_cnt  <= '0;
      r_col_cnt  <= '0;
      r_load_idx <= '0;
      r_s_out    <= '0;
      r_t_out    <= '0;
      r_store_s  <= '0;
      r_init_out <= 1'b0;
    end else begin
      // Strobes are single-cycle unless an accept re-asserts them below.
      r_store_s  <= '0;
      r_init_out <= 1'b0;
      if (w_track) r_col_cnt <= r_col_cnt + REF_LEN_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ref_len  <= ref_len;
            r_ref_cnt  <= '0;
            r_col_cnt  <= '0;
            r_load_idx <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (rd_valid) begin
            r_s_out   <= rd_base;
            r_store_s <= NUM_PE'(1) << r_load_idx;
            if (r_load_idx == IDX_W'(NUM_PE - 1)) begin
              r_state <= (r_ref_len == '0) ? ST_DONE : ST_STREAM;
            end else begin
              r_load_idx <= r_load_idx + IDX_W'(1);
            end
          end
        end
        ST_STREAM: begin
          // A cycle without ref_valid leaves init_out low: a bubble column.
          if (ref_valid) begin
            r_t_out    <= ref_base;
            r_init_out <= 1'b1;
            r_ref_cnt  <= r_ref_cnt + REF_LEN_W'(1);
            if (r_ref_cnt + REF_LEN_W'(1) == r_ref_len) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_col_cnt == r_ref_len) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sw_max_tracker #(
    .WIDTH (WIDTH),
    .POS_W (REF_LEN_W)
  ) u_max (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_en        (w_track),
    .i_v         (V_last),
    .i_pos       (r_col_cnt),
    .o_max_score (max_score),
    .o_max_pos   (max_pos)
  );

  assign rd_ready  = (r_state == ST_LOAD);
  assign ref_ready = (r_state == ST_STREAM);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign S_out     = r_s_out;
  assign store_S   = r_store_s;
  assign T_out     = r_t_out;
  assign init_out  = r_init_out;

endmodule

// File: tb/tb_sw_array_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sw_array_ctrl
// Bench for sw_array_ctrl. The PE array is modelled as a NUM_PE-cycle delay of
// init_out; V_last comes from a per-column score table. Expected results are
// computed from the job description (read string, reference string, table).
// ----------------------------------------------------------------------------
module tb_sw_array_ctrl;

  localparam int NUM_PE    = 6;
  localparam int WIDTH     = 10;
  localparam int REF_LEN_W = 16;
  localparam int TBL       = 40;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [REF_LEN_W-1:0]    ref_len;
  logic [1:0]              rd_base;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [1:0]              ref_base;
  logic                    ref_valid;
  logic                    ref_ready;
  logic [1:0]              S_out;
  logic [NUM_PE-1:0]       store_S;
  logic [1:0]              T_out;
  logic                    init_out;
  logic signed [WIDTH-1:0] V_last;
  logic                    init_last;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] max_score;
  logic [REF_LEN_W-1:0]    max_pos;

  always #5 clk = ~clk;

  sw_array_ctrl #(
    .NUM_PE    (NUM_PE),
    .WIDTH     (WIDTH),
    .REF_LEN_W (REF_LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ref_len   (ref_len),
    .rd_base   (rd_base),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .ref_base  (ref_base),
    .ref_valid (ref_valid),
    .ref_ready (ref_ready),
    .S_out     (S_out),
    .store_S   (store_S),
    .T_out     (T_out),
    .init_out  (init_out),
    .V_last    (V_last),
    .init_last (init_last),
    .busy      (busy),
    .done      (done),
    .max_score (max_score),
    .max_pos   (max_pos)
  );

  // Job description
  logic [1:0]              job_rd  [NUM_PE];
  logic [1:0]              job_ref [TBL];
  logic signed [WIDTH-1:0] vtbl    [TBL];
  int                      job_len;
  int                      rd_mode;
  logic [31:0]             ref_mask;
  bit                      ref_rand;
  int                      first_acc, last_acc;

  // Array model: column flag ripples through NUM_PE PEs
  logic [NUM_PE-1:0] dl;
  logic              arr_clr;
  int                arr_col;

  always @(posedge clk) begin
    if (rst) dl <= '0;
    else     dl <= {dl[NUM_PE-2:0], init_out};
    if (arr_clr)        arr_col <= 0;
    else if (init_last) arr_col <= arr_col + 1;
  end

  assign init_last = dl[NUM_PE-1];
  // Unqualified cycles carry a large score that must never be picked up.
  assign V_last = (init_last && arr_col < TBL) ? vtbl[arr_col] : 10'sd300;

  // Output monitor
  logic       mon_clr;
  int         cyc, ns, nt, n_done, first_t, last_t, cap_score, cap_pos;
  logic [7:0] obs_s [8];
  logic [1:0] obs_t [64];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      ns <= 0; nt <= 0; n_done <= 0; first_t <= -1; last_t <= -1;
    end else begin
      if (|store_S) begin
        if (ns < 8) obs_s[ns] <= {store_S, S_out};
        ns <= ns + 1;
      end
      if (init_out) begin
        if (nt < 64) obs_t[nt] <= T_out;
        nt <= nt + 1;
        if (first_t < 0) first_t <= cyc;
        last_t <= cyc;
      end
      if (done) begin
        n_done    <= n_done + 1;
        cap_score <= int'(max_score);
        cap_pos   <= int'(max_pos);
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic start_job();
    @(posedge clk); #1;
    start = 1'b1; ref_len = REF_LEN_W'(job_len); mon_clr = 1'b1; arr_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mon_clr = 1'b0; arr_clr = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic load_phase();
    int idx = 0;
    int c = 0;
    bit acc;
    while (idx < NUM_PE && c < 200) begin
      case (rd_mode)
        0:       rd_valid = 1'b1;
        1:       rd_valid = ((c % 2) == 0);
        default: rd_valid = ($urandom_range(0, 2) != 0);
      endcase
      rd_base = job_rd[idx];
      acc = rd_valid && rd_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    rd_valid = 1'b0;
    check("load_accepts", idx, NUM_PE);
    check("rd_ready_after_load", int'(rd_ready), 0);
  endtask

  task automatic ref_phase(input int limit, input bit start_mid);
    int k = 0;
    int c = 0;
    bit acc;
    first_acc = -1; last_acc = -1;
    while (k < limit && c < 600) begin
      ref_valid = ((c >= 32) || ref_mask[c % 32]) &&
                  (!ref_rand || ($urandom_range(0, 3) != 0));
      ref_base  = job_ref[k % TBL];
      acc       = ref_valid && ref_ready;
      start     = start_mid && (c == 3);
      @(posedge clk); #1;
      if (acc) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        k++;
      end
      c++;
    end
    ref_valid = 1'b0;
    start     = 1'b0;
    check("ref_accepts", k, limit);
    if (limit == job_len) check("ref_ready_after_stream", int'(ref_ready), 0);
  endtask

  task automatic finish_phase();
    int c = 0;
    int best = 0;
    int pos = 0;
    logic [5:0] oh;
    while (n_done == 0 && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < job_len; i++)
      if (int'(vtbl[i]) > best) begin best = int'(vtbl[i]); pos = i; end
    check("done_count", n_done, 1);
    check("max_score", cap_score, best);
    check("max_pos", cap_pos, pos);
    check("store_count", ns, NUM_PE);
    for (int i = 0; i < NUM_PE && i < ns; i++) begin
      oh = 6'(1) << i;
      check($sformatf("store_S_S_out[%0d]", i), int'(obs_s[i]), int'({oh, job_rd[i]}));
    end
    check("init_count", nt, job_len);
    for (int i = 0; i < nt && i < job_len; i++)
      check($sformatf("T_out[%0d]", i), int'(obs_t[i]), int'(job_ref[i]));
    if (job_len > 0) check("init_span", last_t - first_t + 1, last_acc - first_acc + 1);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic set_demo();
    logic [1:0] rd6 [NUM_PE];
    logic [1:0] rf8 [8];
    int v8 [8];
    rd6 = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00};
    rf8 = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
    v8  = '{0, 2, 1, 4, 3, 4, 9, 7};
    for (int i = 0; i < NUM_PE; i++) job_rd[i] = rd6[i];
    for (int i = 0; i < TBL; i++) begin
      job_ref[i] = (i < 8) ? rf8[i] : 2'b00;
      vtbl[i]    = (i < 8) ? 10'(v8[i]) : 10'sd0;
    end
    job_len = 8;
  endtask

  task automatic set_random();
    int t;
    for (int i = 0; i < NUM_PE; i++) job_rd[i] = 2'($urandom_range(0, 3));
    for (int i = 0; i < TBL; i++) begin
      job_ref[i] = 2'($urandom_range(0, 3));
      t = int'($urandom_range(0, 60)) - 30;
      vtbl[i] = 10'(t);
    end
    job_len = int'($urandom_range(1, 30));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ref_len = '0; rd_base = '0; rd_valid = 1'b0;
    ref_base = '0; ref_valid = 1'b0; mon_clr = 1'b1; arr_clr = 1'b1;
    for (int i = 0; i < TBL; i++) begin vtbl[i] = '0; job_ref[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mon_clr = 1'b0; arr_clr = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ctrl_outs", int'({store_S, init_out, T_out, S_out, rd_ready, ref_ready}), 0);
    check("rst_max", int'({max_score, max_pos}), 0);

    // Reset in the middle of STREAM abandons the job
    set_random();
    job_len = 12;
    for (int i = 0; i < TBL; i++) vtbl[i] = 10'(i + 5);
    rd_mode = 0; ref_mask = '1; ref_rand = 1'b0;
    start_job();
    load_phase();
    ref_phase(10, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_ctrl_outs", int'({store_S, init_out, T_out, S_out, rd_ready, ref_ready}), 0);
    check("midrst_max_score", int'(max_score), 0);
    check("midrst_max_pos", int'(max_pos), 0);
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_done", n_done, 0);

    // Reference job with toggling read valid
    set_demo();
    rd_mode = 1; ref_mask = '1; ref_rand = 1'b0;
    start_job(); load_phase(); ref_phase(job_len, 1'b0); finish_phase();

    // Same job with two ref_valid bubbles
    set_demo();
    rd_mode = 0; ref_mask = 32'hFFFF_FFED; ref_rand = 1'b0;
    start_job(); load_phase(); ref_phase(job_len, 1'b0); finish_phase();

    // Empty reference
    set_demo();
    job_len = 0;
    rd_mode = 0; ref_mask = '1; ref_rand = 1'b0;
    start_job(); load_phase(); finish_phase();

    // All-negative scores, start pulse during STREAM ignored
    set_demo();
    for (int i = 0; i < TBL; i++) vtbl[i] = -10'sd4;
    rd_mode = 0; ref_mask = '1; ref_rand = 1'b0;
    start_job(); load_phase(); ref_phase(job_len, 1'b1); finish_phase();

    // Randomized jobs
    for (int j = 0; j < 5; j++) begin
      set_random();
      rd_mode = 2; ref_mask = '1; ref_rand = 1'b1;
      start_job(); load_phase(); ref_phase(job_len, 1'b0); finish_phase();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
